// File: rtl/rst_sequencer.sv
// rst_sequencer: ordered release of N_DOM dependent reset domains.
// Domain 0 is the most basic domain. Domain j depends on every lower domain.
// A software request for domain k re-asserts k..N_DOM-1 only.
// Those domains are then released one at a time, in ascending order,
// after an initial hold period.
module rst_sequencer #(
    parameter int N_DOM     = 4,
    parameter int HOLD_CYC  = 8,
    parameter int STAGE_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DOM-1:0] swrst_req,
    output logic [N_DOM-1:0] rst_ob,
    output logic             busy,
    output logic             done,
    output logic             swrst_ack
);

    localparam int MAX_CYC = (HOLD_CYC > STAGE_CYC) ? HOLD_CYC : STAGE_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int IDX_W   = (N_DOM > 1) ? $clog2(N_DOM) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO   = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DOM - 1);

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_REL  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Index of the lowest set request bit (the most basic domain asked for).
    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_DOM-1:0] req);
        logic [IDX_W-1:0] pos;
        pos = IDX_ZERO;
        for (int i = N_DOM - 1; i >= 0; i--) begin
            if (req[i]) begin
                pos = IDX_W'(i);
            end else begin
                pos = pos;
            end
        end
        return pos;
    endfunction

    // Mask selecting domains base..N_DOM-1 (the domains a reset of base drags along).
    function automatic logic [N_DOM-1:0] upper_mask(input logic [IDX_W-1:0] base);
        logic [N_DOM-1:0] m;
        m = {N_DOM{1'b0}};
        for (int i = 0; i < N_DOM; i++) begin
            if (IDX_W'(i) >= base) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    state_t           state_r, state_s;
    logic [IDX_W-1:0] k_r, k_s;
    logic [IDX_W-1:0] idx_r, idx_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [N_DOM-1:0] rst_ob_r, rst_ob_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             ack_r, ack_s;
    logic [IDX_W-1:0] req_low_s;
    logic [IDX_W-1:0] base_s;

    // Request decode: lowest requested domain and the new base index.
    always_comb begin
        req_low_s = lowest_set(swrst_req);
        base_s    = req_low_s;
        if (state_r == ST_RUN) begin
            base_s = req_low_s;
        end else if (k_r < req_low_s) begin
            base_s = k_r;
        end else begin
            base_s = req_low_s;
        end
    end

    // Next-state and next-output logic; a request overrides any release on the same edge.
    always_comb begin
        state_s  = state_r;
        k_s      = k_r;
        idx_s    = idx_r;
        cnt_s    = cnt_r;
        rst_ob_s = rst_ob_r;
        done_s   = 1'b0;
        ack_s    = 1'b0;
        if (swrst_req != {N_DOM{1'b0}}) begin
            k_s      = base_s;
            rst_ob_s = rst_ob_r & ~upper_mask(base_s);
            state_s  = ST_HOLD;
            cnt_s    = CNT_ZERO;
            ack_s    = 1'b1;
        end else begin
            case (state_r)
                ST_HOLD: begin
                    if (cnt_r == HOLD_LAST) begin
                        state_s = ST_REL;
                        cnt_s   = CNT_ZERO;
                        idx_s   = k_r;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_REL: begin
                    if (cnt_r == STAGE_LAST) begin
                        for (int i = 0; i < N_DOM; i++) begin
                            if (idx_r == IDX_W'(i)) begin
                                rst_ob_s[i] = 1'b1;
                            end else begin
                                rst_ob_s[i] = rst_ob_r[i];
                            end
                        end
                        cnt_s = CNT_ZERO;
                        if (idx_r == IDX_LAST) begin
                            state_s = ST_RUN;
                            done_s  = 1'b1;
                        end else begin
                            idx_s = idx_r + IDX_ONE;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    cnt_s    = CNT_ZERO;
                    rst_ob_s = {N_DOM{1'b1}};
                end
                default: begin
                    state_s  = ST_HOLD;
                    k_s      = IDX_ZERO;
                    idx_s    = IDX_ZERO;
                    cnt_s    = CNT_ZERO;
                    rst_ob_s = {N_DOM{1'b0}};
                end
            endcase
        end
        if (state_s == ST_RUN) begin
            busy_s = 1'b0;
        end else begin
            busy_s = 1'b1;
        end
    end

    // State and output registers; rst forces the power-on starting point.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_HOLD;
            k_r      <= IDX_ZERO;
            idx_r    <= IDX_ZERO;
            cnt_r    <= CNT_ZERO;
            rst_ob_r <= {N_DOM{1'b0}};
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
            ack_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            k_r      <= k_s;
            idx_r    <= idx_s;
            cnt_r    <= cnt_s;
            rst_ob_r <= rst_ob_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            ack_r    <= ack_s;
        end
    end

    assign rst_ob    = rst_ob_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign swrst_ack = ack_r;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed, table-driven bench for rst_sequencer.
// Instance a uses the default parameters. Instance b uses the minimal
// configuration: one domain, one-cycle hold and stage.
// Edge 0 is the last edge at which rst is sampled high.
module tb_rst_sequencer;

    logic       clk;
    logic       rst_a, rst_b;
    logic [3:0] req_a;
    logic [0:0] req_b;
    logic [3:0] ob_a;
    logic [0:0] ob_b;
    logic       busy_a, done_a, ack_a;
    logic       busy_b, done_b, ack_b;

    int n_checks;
    int n_fail;

    typedef struct {
        int         dut;
        int         cyc;
        logic       rst;
        logic [3:0] req;
        logic [3:0] ob;
        logic       busy;
        logic       done;
        logic       ack;
    } vec_t;

    vec_t vecs[$];

    rst_sequencer #(.N_DOM(4), .HOLD_CYC(8), .STAGE_CYC(16)) u_a (
        .clk(clk), .rst(rst_a), .swrst_req(req_a),
        .rst_ob(ob_a), .busy(busy_a), .done(done_a), .swrst_ack(ack_a)
    );

    rst_sequencer #(.N_DOM(1), .HOLD_CYC(1), .STAGE_CYC(1)) u_b (
        .clk(clk), .rst(rst_b), .swrst_req(req_b),
        .rst_ob(ob_b), .busy(busy_b), .done(done_b), .swrst_ack(ack_b)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic add(input int dut, input int cyc, input logic r, input logic [3:0] q,
                       input logic [3:0] ob, input logic b, input logic d, input logic a);
        vec_t v;
        v.dut = dut; v.cyc = cyc; v.rst = r; v.req = q;
        v.ob = ob; v.busy = b; v.done = d; v.ack = a;
        vecs.push_back(v);
    endtask

    initial begin
        logic [3:0] got_ob;
        logic       got_busy, got_done, got_ack;
        logic       seen_done_a;
        n_checks = 0;
        n_fail   = 0;
        seen_done_a = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1; req_a = 4'b0000; req_b = 1'b0;

        // Instance a: power-on sequence.
        add(0,   0, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        add(0,  23, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        add(0,  24, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0);
        add(0,  39, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0);
        add(0,  40, 1'b0, 4'b0000, 4'b0011, 1'b1, 1'b0, 1'b0);
        add(0,  56, 1'b0, 4'b0000, 4'b0111, 1'b1, 1'b0, 1'b0);
        add(0,  71, 1'b0, 4'b0000, 4'b0111, 1'b1, 1'b0, 1'b0);
        add(0,  72, 1'b0, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0);
        add(0,  73, 1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
        add(0,  99, 1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
        // Software reset of domain 2 from RUN, then domain 1 mid-sequence.
        add(0, 100, 1'b0, 4'b0100, 4'b0011, 1'b1, 1'b0, 1'b1);
        add(0, 101, 1'b0, 4'b0000, 4'b0011, 1'b1, 1'b0, 1'b0);
        add(0, 123, 1'b0, 4'b0000, 4'b0011, 1'b1, 1'b0, 1'b0);
        add(0, 124, 1'b0, 4'b0000, 4'b0111, 1'b1, 1'b0, 1'b0);
        add(0, 129, 1'b0, 4'b0000, 4'b0111, 1'b1, 1'b0, 1'b0);
        add(0, 130, 1'b0, 4'b0010, 4'b0001, 1'b1, 1'b0, 1'b1);
        add(0, 131, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0);
        add(0, 153, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0);
        add(0, 154, 1'b0, 4'b0000, 4'b0011, 1'b1, 1'b0, 1'b0);
        add(0, 170, 1'b0, 4'b0000, 4'b0111, 1'b1, 1'b0, 1'b0);
        add(0, 185, 1'b0, 4'b0000, 4'b0111, 1'b1, 1'b0, 1'b0);
        add(0, 186, 1'b0, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0);
        add(0, 187, 1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
        // Held request on domain 3, edges 200..249.
        add(0, 200, 1'b0, 4'b1000, 4'b0111, 1'b1, 1'b0, 1'b1);
        add(0, 225, 1'b0, 4'b1000, 4'b0111, 1'b1, 1'b0, 1'b1);
        add(0, 249, 1'b0, 4'b1000, 4'b0111, 1'b1, 1'b0, 1'b1);
        add(0, 250, 1'b0, 4'b0000, 4'b0111, 1'b1, 1'b0, 1'b0);
        add(0, 272, 1'b0, 4'b0000, 4'b0111, 1'b1, 1'b0, 1'b0);
        add(0, 273, 1'b0, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0);
        add(0, 274, 1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
        // rst in RUN together with a request: reset wins, no ack.
        add(0, 300, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
        add(0, 301, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        add(0, 324, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0);
        add(0, 349, 1'b0, 4'b0000, 4'b0011, 1'b1, 1'b0, 1'b0);
        // rst mid-sequence restarts from scratch.
        add(0, 350, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        add(0, 373, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        add(0, 374, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0);
        add(0, 390, 1'b0, 4'b0000, 4'b0011, 1'b1, 1'b0, 1'b0);
        add(0, 406, 1'b0, 4'b0000, 4'b0111, 1'b1, 1'b0, 1'b0);
        add(0, 421, 1'b0, 4'b0000, 4'b0111, 1'b1, 1'b0, 1'b0);
        // Request on the final release edge: base stays 0, all re-asserted, no done.
        add(0, 422, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b0, 1'b1);
        add(0, 423, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        add(0, 445, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        add(0, 446, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0);
        add(0, 462, 1'b0, 4'b0000, 4'b0011, 1'b1, 1'b0, 1'b0);
        add(0, 478, 1'b0, 4'b0000, 4'b0111, 1'b1, 1'b0, 1'b0);
        add(0, 494, 1'b0, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0);
        add(0, 495, 1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
        // Instance b: minimal configuration.
        add(1,   0, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        add(1,   1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        add(1,   2, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0);
        add(1,   3, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0);
        add(1,  10, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1);
        add(1,  11, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        add(1,  12, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0);
        add(1,  13, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0);
        add(1,  22, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1);
        add(1,  23, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        add(1,  24, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0);

        for (int e = -2; e <= 500; e++) begin
            // Default stimulus plus the hand-written held-request windows.
            rst_a = (e <= 0) ? 1'b1 : 1'b0;
            rst_b = (e <= 0) ? 1'b1 : 1'b0;
            req_a = (e >= 200 && e <= 249) ? 4'b1000 : 4'b0000;
            req_b = (e >= 20 && e <= 22) ? 1'b1 : 1'b0;
            foreach (vecs[i]) begin
                if (vecs[i].cyc == e) begin
                    if (vecs[i].dut == 0) begin
                        rst_a = rst_a | vecs[i].rst;
                        req_a = req_a | vecs[i].req;
                    end else begin
                        rst_b = rst_b | vecs[i].rst;
                        req_b = req_b | vecs[i].req[0:0];
                    end
                end
            end
            @(posedge clk);
            #1;
            if (e == -1) begin
                n_checks++;
                if (ob_a !== 4'b0000 || busy_a !== 1'b1 || done_a !== 1'b0 || ack_a !== 1'b0 ||
                    ob_b !== 1'b0 || busy_b !== 1'b1 || done_b !== 1'b0 || ack_b !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset state at edge %0d: a ob=%b busy=%b done=%b ack=%b, b ob=%b busy=%b done=%b ack=%b",
                             e, ob_a, busy_a, done_a, ack_a, ob_b, busy_b, done_b, ack_b);
                end
            end
            if (e >= 1 && e <= 80 && done_a === 1'b1) begin
                seen_done_a = 1'b1;
            end
            if (e == 80) begin
                n_checks++;
                if (seen_done_a !== 1'b1) begin
                    n_fail++;
                    $display("FAIL timeout: no done pulse from dut0 power-on sequence by edge %0d", e);
                end
            end
            foreach (vecs[i]) begin
                if (vecs[i].cyc == e) begin
                    if (vecs[i].dut == 0) begin
                        got_ob = ob_a; got_busy = busy_a; got_done = done_a; got_ack = ack_a;
                    end else begin
                        got_ob = {3'b000, ob_b}; got_busy = busy_b; got_done = done_b; got_ack = ack_b;
                    end
                    n_checks++;
                    if (got_ob !== vecs[i].ob || got_busy !== vecs[i].busy ||
                        got_done !== vecs[i].done || got_ack !== vecs[i].ack) begin
                        n_fail++;
                        $display("FAIL dut%0d edge %0d: got ob=%b busy=%b done=%b ack=%b, expected ob=%b busy=%b done=%b ack=%b",
                                 vecs[i].dut, e, got_ob, got_busy, got_done, got_ack,
                                 vecs[i].ob, vecs[i].busy, vecs[i].done, vecs[i].ack);
                    end
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 SHALL have parameter N_DOM, default 4, number of reset domains (1..16).
REQ-002 SHALL have parameter HOLD_CYC, default 8, cycles all targeted domains stay asserted before the first release (>=1).
REQ-003 SHALL have parameter STAGE_CYC, default 16, cycles between consecutive domain releases (>=1).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port swrst_req  input  N_DOM  bit i: request reset of domain i and every higher-index domain; level-sensitive.
REQ-007 SHALL have port rst_ob  output  N_DOM  per-domain reset, lo active, registered.
REQ-008 SHALL have port busy  output  1  high while any sequence is in progress (state != RUN).
REQ-009 SHALL have port done  output  1  one-cycle pulse when the last domain is released.
REQ-010 SHALL have port swrst_ack  output  1  one-cycle pulse the cycle after a request is accepted.

Function
REQ-011 Domain ordering SHALL be fixed: domain 0 is the most basic; domain j depends on every domain i<j; resetting domain k SHALL always also reset domains k..N_DOM-1.
REQ-012 FSM SHALL have exactly three states: HOLD, REL, RUN; registers: state, base index k, release index idx, counter cnt sized for max(HOLD_CYC,STAGE_CYC).
REQ-013 HOLD: cnt SHALL increment each cycle; at the edge where cnt==HOLD_CYC-1 the FSM SHALL go to REL with cnt=0, idx=k.
REQ-014 REL: at the edge where cnt==STAGE_CYC-1, rst_ob[idx] SHALL go 1; if idx==N_DOM-1 the FSM SHALL go to RUN and done SHALL pulse in the following cycle, else idx SHALL increment and cnt SHALL clear.
REQ-015 Timing: with the sequence started at edge T, domain j (j>=k) SHALL release at edge T+HOLD_CYC+(j-k+1)*STAGE_CYC; lower domains SHALL never release after higher ones.
REQ-016 RUN: all rst_ob SHALL be 1; cnt idle; busy 0.
REQ-017 In RUN, if swrst_req!=0 at edge T, with j the lowest set bit: k<=j, rst_ob[N_DOM-1:j]<=0, rst_ob[j-1:0] unchanged, state<=HOLD, cnt<=0, swrst_ack pulses in cycle after T.
REQ-018 In HOLD or REL, if swrst_req!=0 with lowest set bit j: k<=min(k,j), rst_ob[N_DOM-1:min(k,j)]<=0 (already-released domains in that range re-asserted), state<=HOLD, cnt<=0, swrst_ack pulses; this request SHALL take priority over any release scheduled on the same edge.
REQ-019 A request held high SHALL keep its domains in reset (HOLD restarted every cycle) and swrst_ack SHALL pulse every cycle it is accepted; release begins HOLD_CYC cycles after the request drops.
REQ-020 Domains below k SHALL never be touched by a software-initiated sequence.
REQ-021 Priority SHALL be rst > swrst_req > internal counter/release progression.
REQ-022 done and swrst_ack SHALL never be high in the same cycle as rst is sampled high; done SHALL NOT pulse if a request aborts the final release edge.

Reset
REQ-023 While rst is sampled high: rst_ob=all 0, state=HOLD, k=0, idx=0, cnt=0, busy=1, done=0, swrst_ack=0.
REQ-024 After rst drops the full power-on sequence (k=0) SHALL run with no software request needed.
REQ-025 rst asserted mid-sequence or in RUN SHALL abort at once to the REQ-023 state, discarding any in-flight request.

Verification
REQ-026 Defaults, rst high sampled last at edge 0 -> rst_ob[0..3] rise at edges 24, 40, 56, 72; done high only in cycle after edge 72; busy falls with done.
REQ-027 In RUN, 1-cycle swrst_req=4'b0100 at edge 100 -> rst_ob=4'b0011 after edge 100, ack pulse, rst_ob[2] rises edge 124, rst_ob[3] edge 140, done after 140; rst_ob[1:0] stay 1 throughout.
REQ-028 During sequence of REQ-027, swrst_req=4'b0010 pulsed at edge 130 -> rst_ob=4'b0001 after edge 130, k=1, domains 1,2,3 release at edges 154, 170, 186.
REQ-029 swrst_req=4'b1000 held high edges 200..249 -> rst_ob[3]=0 throughout, ack every accepted cycle, rst_ob[3] rises edge 250+8+16-1=273 (last acceptance edge 249, release at 249+24).
REQ-030 rst pulsed high at edge 50 during power-on sequence -> all rst_ob=0 after edge 50, full sequence restarts, domain 0 releases at edge 74.
REQ-031 N_DOM=1, HOLD_CYC=1, STAGE_CYC=1 -> rst_ob rises at edge 2 after reset; request at edge 10 -> rst_ob low, rises edge 12, done after edge 12.
